tick_bcd_counter: RTL and testbench

Counts rising edges of a slow square wave produced by the upstream clock divider stage. The divider's divided output arrives on `tick_in` as an ordinary data signal, and this block runs it through a synchronizer and an edge detector on the fast clock. Each detected edge steps a two-digit BCD counter up or down, modulo `MODULO`. The block drives the seconds/minutes style digit pair for the display stage and emits a one-cycle wrap pulse that the next counter stage chains on.

---
 rtl/tick_bcd_counter_if.sv | 21 ++
 rtl/tick_bcd_counter.sv | 90 +++++++++
 tb/tb_tick_bcd_counter.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tick_bcd_counter_if.sv
// rtl/tick_bcd_counter_if.sv - tick/control inputs and BCD digit outputs of tick_bcd_counter
interface tick_bcd_counter_if;
  logic       tick_in;
  logic       en;
  logic       up;
  logic       clr;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       wrap;
  logic       tick_seen;

  modport master (
    output tick_in, en, up, clr,
    input  ones, tens, wrap, tick_seen
  );

  modport slave (
    input  tick_in, en, up, clr,
    output ones, tens, wrap, tick_seen
  );
endinterface

// File: rtl/tick_bcd_counter.sv
// rtl/tick_bcd_counter.sv - synchronised rising-edge counter with two BCD digits, modulo MODULO
module tick_bcd_counter #(
  parameter int MODULO      = 60,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clkin,
  input  logic           rstn,
  tick_bcd_counter_if.slave bus
);

  localparam logic [3:0] LAST_ONES = 4'((MODULO - 1) % 10);
  localparam logic [3:0] LAST_TENS = 4'((MODULO - 1) / 10);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise;
  logic [3:0]             ones_q, tens_q, ones_d, tens_d;
  logic                   wrap_q, wrap_d;
  logic                   seen_q;
  logic                   at_last, at_zero;

  // Edge detector runs every cycle so a disabled edge is consumed, never deferred.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.tick_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise    = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign at_last = (ones_q == LAST_ONES) && (tens_q == LAST_TENS);
  assign at_zero = (ones_q == 4'd0) && (tens_q == 4'd0);

  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    wrap_d = 1'b0;
    if (bus.clr) begin
      ones_d = 4'd0;
      tens_d = 4'd0;
    end else if (rise && bus.en) begin
      if (bus.up) begin
        if (at_last) begin
          ones_d = 4'd0;
          tens_d = 4'd0;
          wrap_d = 1'b1;
        end else if (ones_q == 4'd9) begin
          ones_d = 4'd0;
          tens_d = tens_q + 4'd1;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end else begin
        if (at_zero) begin
          ones_d = LAST_ONES;
          tens_d = LAST_TENS;
          wrap_d = 1'b1;
        end else if (ones_q == 4'd0) begin
          ones_d = 4'd9;
          tens_d = tens_q - 4'd1;
        end else begin
          ones_d = ones_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      ones_q <= 4'd0;
      tens_q <= 4'd0;
      wrap_q <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
      wrap_q <= wrap_d;
      seen_q <= rise;
    end
  end

  assign bus.ones      = ones_q;
  assign bus.tens      = tens_q;
  assign bus.wrap      = wrap_q;
  assign bus.tick_seen = seen_q;

endmodule

// File: tb/tb_tick_bcd_counter.sv
// tb/tb_tick_bcd_counter.sv - randomized self-checking bench for tick_bcd_counter (MODULO 60 and 12)
module tb_tick_bcd_counter;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  tick_bcd_counter_if a_if ();
  tick_bcd_counter_if b_if ();

  tick_bcd_counter #(.MODULO(60), .SYNC_STAGES(2)) dut_a (.clkin(clk), .rstn(rstn), .bus(a_if.slave));
  tick_bcd_counter #(.MODULO(12), .SYNC_STAGES(2)) dut_b (.clkin(clk), .rstn(rstn), .bus(b_if.slave));

  int total = 0;
  int bad   = 0;
  int cnt_a = 0;
  int seen_a = 0, wraps_a = 0, seen_b = 0, wraps_b = 0;

  // Pulse monitors count high cycles, so a pulse wider than one cycle shows up as extra counts.
  always @(posedge clk) begin
    if (a_if.tick_seen === 1'b1) seen_a <= seen_a + 1;
    if (a_if.wrap === 1'b1)      wraps_a <= wraps_a + 1;
    if (b_if.tick_seen === 1'b1) seen_b <= seen_b + 1;
    if (b_if.wrap === 1'b1)      wraps_b <= wraps_b + 1;
  end

  task automatic edge_a();
    @(negedge clk) a_if.tick_in = 1'b1;
    repeat ($urandom_range(3, 6)) @(negedge clk);
    a_if.tick_in = 1'b0;
    repeat ($urandom_range(3, 6)) @(negedge clk);
  endtask

  task automatic clr_a();
    @(negedge clk) a_if.clr = 1'b1;
    @(negedge clk) a_if.clr = 1'b0;
    cnt_a = 0;
  endtask

  task automatic test_reset();
    a_if.tick_in = 0; a_if.en = 1; a_if.up = 1; a_if.clr = 0;
    b_if.tick_in = 0; b_if.en = 1; b_if.up = 1; b_if.clr = 0;
    rstn = 0;
    repeat (6) @(negedge clk) begin
      a_if.tick_in = ~a_if.tick_in;
      b_if.tick_in = ~b_if.tick_in;
    end
    total++;
    if ({a_if.ones, a_if.tens, a_if.wrap, a_if.tick_seen} !== 10'd0 ||
        {b_if.ones, b_if.tens, b_if.wrap, b_if.tick_seen} !== 10'd0) begin
      bad++;
      $display("FAIL reset_outputs a=%h/%h/%b/%b b=%h/%h/%b/%b required all 0",
               a_if.tens, a_if.ones, a_if.wrap, a_if.tick_seen, b_if.tens, b_if.ones, b_if.wrap, b_if.tick_seen);
    end
    a_if.tick_in = 0; b_if.tick_in = 0;
    @(negedge clk) rstn = 1;
    repeat (3) @(negedge clk);
    a_if.tick_in = 1;
    @(posedge clk);
    @(posedge clk); #1;
    total++;
    if (a_if.ones !== 4'd0) begin
      bad++; $display("FAIL latency_early ones=%0d required 0", a_if.ones);
    end
    @(posedge clk); #1;
    total++;
    if (a_if.ones !== 4'd1 || a_if.tens !== 4'd0 || a_if.tick_seen !== 1'b1) begin
      bad++; $display("FAIL latency_k2 tens/ones=%0d/%0d seen=%b required 0/1 seen=1", a_if.tens, a_if.ones, a_if.tick_seen);
    end
    repeat (4) @(negedge clk);
    a_if.tick_in = 0;
    repeat (4) @(negedge clk);
    // High level present at reset release counts once it reaches the synchronizer output.
    rstn = 0;
    a_if.tick_in = 1;
    repeat (2) @(negedge clk);
    rstn = 1;
    repeat (5) @(negedge clk);
    total++;
    if (a_if.ones !== 4'd1 || a_if.tens !== 4'd0) begin
      bad++; $display("FAIL high_at_release tens/ones=%0d/%0d required 0/1", a_if.tens, a_if.ones);
    end
    a_if.tick_in = 0;
    repeat (4) @(negedge clk);
    cnt_a = 1;
  endtask

  task automatic test_up_wrap();
    int w0;
    clr_a();
    a_if.up = 1; a_if.en = 1;
    w0 = wraps_a;
    for (int i = 1; i <= 60; i++) begin
      edge_a();
      cnt_a = (cnt_a + 1) % 60;
      total++;
      if (a_if.ones !== 4'(cnt_a % 10) || a_if.tens !== 4'(cnt_a / 10)) begin
        bad++; $display("FAIL up_step%0d tens/ones=%0d/%0d required %0d/%0d", i, a_if.tens, a_if.ones, cnt_a / 10, cnt_a % 10);
      end
      if (i == 10) begin
        total++;
        if (a_if.ones !== 4'd0 || a_if.tens !== 4'd1) begin
          bad++; $display("FAIL up_09_to_10 tens/ones=%0d/%0d required 1/0", a_if.tens, a_if.ones);
        end
      end
      if (i == 59) begin
        total++;
        if (a_if.ones !== 4'd9 || a_if.tens !== 4'd5 || wraps_a != w0) begin
          bad++; $display("FAIL up_59 tens/ones=%0d/%0d wraps=%0d required 5/9 wraps=0", a_if.tens, a_if.ones, wraps_a - w0);
        end
      end
    end
    total++;
    if (a_if.ones !== 4'd0 || a_if.tens !== 4'd0 || wraps_a - w0 != 1) begin
      bad++; $display("FAIL up_wrap tens/ones=%0d/%0d wrap_cycles=%0d required 0/0 wrap_cycles=1", a_if.tens, a_if.ones, wraps_a - w0);
    end
  endtask

  task automatic test_down_wrap();
    int w0;
    clr_a();
    a_if.up = 0; a_if.en = 1;
    w0 = wraps_a;
    edge_a();
    cnt_a = 59;
    total++;
    if (a_if.ones !== 4'd9 || a_if.tens !== 4'd5 || wraps_a - w0 != 1) begin
      bad++; $display("FAIL down_wrap tens/ones=%0d/%0d wrap_cycles=%0d required 5/9 wrap_cycles=1", a_if.tens, a_if.ones, wraps_a - w0);
    end
    for (int i = 0; i < 10; i++) begin
      edge_a();
      cnt_a = cnt_a - 1;
      total++;
      if (a_if.ones > 4'd9 || a_if.tens > 4'd9 || a_if.ones !== 4'(cnt_a % 10) || a_if.tens !== 4'(cnt_a / 10)) begin
        bad++; $display("FAIL down_step%0d tens/ones=%0d/%0d required %0d/%0d", i, a_if.tens, a_if.ones, cnt_a / 10, cnt_a % 10);
      end
    end
    total++;
    if (a_if.ones !== 4'd9 || a_if.tens !== 4'd4) begin
      bad++; $display("FAIL down_49 tens/ones=%0d/%0d required 4/9", a_if.tens, a_if.ones);
    end
  endtask

  task automatic test_enable();
    int s0;
    int n;
    clr_a();
    a_if.up = 1; a_if.en = 1;
    n = $urandom_range(1, 5);
    for (int i = 0; i < n; i++) edge_a();
    cnt_a = n;
    a_if.en = 0;
    s0 = seen_a;
    for (int i = 0; i < 5; i++) edge_a();
    total++;
    if (a_if.ones !== 4'(cnt_a) || a_if.tens !== 4'd0 || seen_a - s0 != 5) begin
      bad++; $display("FAIL enable_gate ones=%0d seen=%0d required ones=%0d seen=5", a_if.ones, seen_a - s0, cnt_a);
    end
    @(negedge clk) a_if.tick_in = 1;
    repeat (5) @(negedge clk);
    a_if.en = 1;
    repeat (5) @(negedge clk);
    total++;
    if (a_if.ones !== 4'(cnt_a)) begin
      bad++; $display("FAIL enable_stale ones=%0d required %0d", a_if.ones, cnt_a);
    end
    a_if.tick_in = 0;
    repeat (5) @(negedge clk);
    edge_a();
    cnt_a++;
    total++;
    if (a_if.ones !== 4'(cnt_a)) begin
      bad++; $display("FAIL enable_next ones=%0d required %0d", a_if.ones, cnt_a);
    end
  endtask

  task automatic test_clr_priority();
    clr_a();
    a_if.up = 1; a_if.en = 1;
    for (int i = 0; i < 37; i++) edge_a();
    total++;
    if (a_if.ones !== 4'd7 || a_if.tens !== 4'd3) begin
      bad++; $display("FAIL clr_setup tens/ones=%0d/%0d required 3/7", a_if.tens, a_if.ones);
    end
    @(negedge clk) a_if.tick_in = 1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk) a_if.clr = 1;
    @(posedge clk); #1;
    total++;
    if (a_if.ones !== 4'd0 || a_if.tens !== 4'd0 || a_if.wrap !== 1'b0 || a_if.tick_seen !== 1'b1) begin
      bad++; $display("FAIL clr_with_rise tens/ones=%0d/%0d wrap=%b seen=%b required 0/0 wrap=0 seen=1",
                      a_if.tens, a_if.ones, a_if.wrap, a_if.tick_seen);
    end
    @(negedge clk) a_if.clr = 0;
    repeat (3) @(negedge clk);
    a_if.tick_in = 0;
    repeat (4) @(negedge clk);
    cnt_a = 0;
  endtask

  task automatic test_random();
    int w0;
    int exp_w;
    bit u, e;
    clr_a();
    w0 = wraps_a;
    exp_w = 0;
    for (int i = 0; i < 50; i++) begin
      if ($urandom_range(0, 7) == 0) clr_a();
      u = 1'($urandom_range(0, 1));
      e = ($urandom_range(0, 3) != 0);
      a_if.up = u; a_if.en = e;
      edge_a();
      if (e) begin
        if (u) begin
          if (cnt_a == 59) exp_w++;
          cnt_a = (cnt_a + 1) % 60;
        end else begin
          if (cnt_a == 0) exp_w++;
          cnt_a = (cnt_a + 59) % 60;
        end
      end
      total++;
      if (a_if.ones !== 4'(cnt_a % 10) || a_if.tens !== 4'(cnt_a / 10)) begin
        bad++; $display("FAIL random_step%0d tens/ones=%0d/%0d required %0d/%0d", i, a_if.tens, a_if.ones, cnt_a / 10, cnt_a % 10);
      end
    end
    total++;
    if (wraps_a - w0 != exp_w) begin
      bad++; $display("FAIL random_wraps got=%0d required=%0d", wraps_a - w0, exp_w);
    end
  endtask

  task automatic test_fast_source();
    int w0, n, rises, c, exp_w;
    bit u;
    for (int run = 0; run < 2; run++) begin
      u = 1'($urandom_range(0, 1));
      b_if.up = u; b_if.en = 1;
      @(negedge clk) b_if.clr = 1;
      @(negedge clk) b_if.clr = 0;
      w0 = wraps_b;
      n = 120 + $urandom_range(0, 20);
      rises = 0;
      for (int i = 0; i < n; i++) begin
        @(negedge clk) b_if.tick_in = ~b_if.tick_in;
        if (b_if.tick_in) rises++;
      end
      @(negedge clk) b_if.tick_in = 0;
      repeat (6) @(negedge clk);
      c = 0; exp_w = 0;
      for (int i = 0; i < rises; i++) begin
        if (u) begin
          if (c == 11) exp_w++;
          c = (c + 1) % 12;
        end else begin
          if (c == 0) exp_w++;
          c = (c + 11) % 12;
        end
      end
      total++;
      if (b_if.ones !== 4'(c % 10) || b_if.tens !== 4'(c / 10) || wraps_b - w0 != exp_w) begin
        bad++; $display("FAIL fast_run%0d up=%b tens/ones=%0d/%0d wraps=%0d required %0d/%0d wraps=%0d",
                        run, u, b_if.tens, b_if.ones, wraps_b - w0, c / 10, c % 10, exp_w);
      end
    end
  endtask

  task automatic test_reset_mid();
    int s0, w0;
    b_if.up = 1; b_if.en = 1;
    for (int i = 0; i < 37; i++) @(negedge clk) b_if.tick_in = ~b_if.tick_in;
    @(posedge clk);
    #2 rstn = 0;
    #1;
    total++;
    if ({b_if.ones, b_if.tens, b_if.wrap, b_if.tick_seen} !== 10'd0) begin
      bad++; $display("FAIL async_reset b=%0d/%0d wrap=%b seen=%b required all 0", b_if.tens, b_if.ones, b_if.wrap, b_if.tick_seen);
    end
    b_if.tick_in = 0;
    @(negedge clk) rstn = 1;
    s0 = seen_b; w0 = wraps_b;
    repeat (6) @(negedge clk);
    total++;
    if (seen_b != s0 || wraps_b != w0 || b_if.ones !== 4'd0 || b_if.tens !== 4'd0) begin
      bad++; $display("FAIL reset_release seen=%0d wraps=%0d ones=%0d required 0 0 0", seen_b - s0, wraps_b - w0, b_if.ones);
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_enable();
    test_clr_priority();
    test_random();
    test_fast_source();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
